baccarat_fsm: RTL and testbench
===============================

BACCARAT_FSM -- requirements
Module: baccarat_fsm

Interface
REQ-001 Parameters: none. All state encodings are internal and fixed.
REQ-002 slow_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetb  input  1  reset, synchronous and active-low, sampled on slow_clock rising edge.
REQ-004 pscore  input  4  player hand score, 0..9, combinational from the card registers.
REQ-005 dscore  input  4  dealer hand score, 0..9, combinational from the card registers.
REQ-006 pcard3  input  4  raw player third card: 0 = none, 1..13 = A..K.
REQ-007 load_pcard1, load_pcard2, load_pcard3  output  1 each  one-cycle player card-register load strobes.
REQ-008 load_dcard1, load_dcard2, load_dcard3  output  1 each  one-cycle dealer card-register load strobes.
REQ-009 player_win_light  output  1  player wins, or tie.
REQ-010 dealer_win_light  output  1  dealer wins, or tie.
REQ-011 done  output  1  hand complete.

Function
REQ-012 States SHALL be: RST, P1, D1, P2, D2, EVAL, P3, BEVAL, D3, DONE.
REQ-013 Outputs SHALL be Moore, decoded from the current state only, except the lights, which also use pscore/dscore in DONE.
REQ-014 Load strobe per state: P1→load_pcard1, D1→load_dcard1, P2→load_pcard2, D2→load_dcard2, P3→load_pcard3, D3→load_dcard3.
REQ-015 Every other state SHALL drive all six load strobes to 0; at most one strobe is high in any cycle.
REQ-016 Fixed transition sequence: RST→P1→D1→P2→D2→EVAL, one slow_clock cycle per state; no handshake.
REQ-017 EVAL: pscore or dscore equal to 8 or 9 (natural) → DONE.
REQ-018 EVAL, no natural, pscore 0..5 → P3.
REQ-019 EVAL, no natural, pscore 6..7, dscore 0..5 → D3.
REQ-020 EVAL, no natural, pscore 6..7, dscore 6..7 → DONE.
REQ-021 P3 → BEVAL unconditionally; pcard3 is valid from BEVAL onward.
REQ-022 BEVAL SHALL compute v3 = pcard3 if pcard3 ≤ 9, else 0.
REQ-023 BEVAL → D3 when: dscore 0..2; dscore 3 and v3≠8; dscore 4 and v3 in 2..7; dscore 5 and v3 in 4..7; dscore 6 and v3 in 6..7.
REQ-024 BEVAL → DONE in all other cases, including dscore 7.
REQ-025 D3 → DONE unconditionally.
REQ-026 DONE SHALL hold until reset and ignore all inputs except resetb.
REQ-027 In DONE: done=1; player_win_light = (pscore ≥ dscore); dealer_win_light = (dscore ≥ pscore); tie lights both.
REQ-028 Outside DONE: done=0 and both lights 0.
REQ-029 Score compares SHALL be unsigned 4-bit.
REQ-030 Latency from reset release: natural hand reaches DONE in 6 cycles; player-stand/banker-draw in 7; player-draw/banker-stand in 8; both draw in 9.
REQ-031 Unreachable state encodings SHALL transition to RST on the next edge.

Reset
REQ-032 A rising edge with resetb=0 SHALL force state RST from any state, including mid-hand (e.g. P3 or D3).
REQ-033 In RST all outputs SHALL be 0.
REQ-034 resetb low SHALL override every transition; no asynchronous path exists.
REQ-035 The first edge with resetb=1 SHALL move RST→P1.

Verification
REQ-036 Natural: D2 with pscore=8, dscore=3 → EVAL→DONE; player_win_light=1, dealer_win_light=0; load_pcard3 and load_dcard3 never asserted.
REQ-037 Both draw: pscore=4, dscore=5, then pcard3=4 → P3, BEVAL, D3 asserted in order. Final pscore=6, dscore=7 → dealer_win_light=1 only; done at cycle 9.
REQ-038 Player stands: pscore=6, dscore=5 → EVAL→D3. Final dscore=6 → both lights=1 (tie).
REQ-039 Face third card: pscore=2, dscore=6, pcard3=12 (v3=0) → BEVAL→DONE; load_dcard3 never asserted.
REQ-040 Banker 3 with v3=8: pscore=1, dscore=3, pcard3=8 → no D3. Banker 3 with pcard3=9 → D3.
REQ-041 Reset mid-hand: resetb=0 during P3 → next state RST, all outputs 0. Release resetb → P1 with load_pcard1=1 on the following cycle.

Source files
------------

// File: rtl/baccarat_fsm.sv
// Baccarat dealing sequencer: walks the four opening cards, applies the
// natural / player / banker third-card rules, then latches the winner lights.
module baccarat_fsm (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
);

    typedef enum logic [3:0] {
        ST_RST   = 4'd0,
        ST_P1    = 4'd1,
        ST_D1    = 4'd2,
        ST_P2    = 4'd3,
        ST_D2    = 4'd4,
        ST_EVAL  = 4'd5,
        ST_P3    = 4'd6,
        ST_BEVAL = 4'd7,
        ST_D3    = 4'd8,
        ST_DONE  = 4'd9
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic       natural;
    logic       player_draws;
    logic       dealer_stands_draws;
    logic [3:0] v3;
    logic       banker_draws;

    // Face cards and tens count as zero toward the banker's decision.
    assign v3 = (pcard3 <= 4'd9) ? pcard3 : 4'd0;

    assign natural             = (pscore >= 4'd8) || (dscore >= 4'd8);
    assign player_draws        = (pscore <= 4'd5);
    assign dealer_stands_draws = (dscore <= 4'd5);

    // Banker tableau applied once the player has taken a third card.
    always_comb begin
        banker_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (v3 != 4'd8);
            4'd4:             banker_draws = (v3 >= 4'd2) && (v3 <= 4'd7);
            4'd5:             banker_draws = (v3 >= 4'd4) && (v3 <= 4'd7);
            4'd6:             banker_draws = (v3 >= 4'd6) && (v3 <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_reg <= ST_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_RST;
        case (state_reg)
            ST_RST:  state_next = ST_P1;
            ST_P1:   state_next = ST_D1;
            ST_D1:   state_next = ST_P2;
            ST_P2:   state_next = ST_D2;
            ST_D2:   state_next = ST_EVAL;
            ST_EVAL: begin
                if (natural) begin
                    state_next = ST_DONE;
                end else if (player_draws) begin
                    state_next = ST_P3;
                end else if (dealer_stands_draws) begin
                    state_next = ST_D3;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_P3:    state_next = ST_BEVAL;
            ST_BEVAL: state_next = banker_draws ? ST_D3 : ST_DONE;
            ST_D3:    state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_RST;
        endcase
    end

    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        done             = 1'b0;
        case (state_reg)
            ST_P1: load_pcard1 = 1'b1;
            ST_D1: load_dcard1 = 1'b1;
            ST_P2: load_pcard2 = 1'b1;
            ST_D2: load_dcard2 = 1'b1;
            ST_P3: load_pcard3 = 1'b1;
            ST_D3: load_dcard3 = 1'b1;
            ST_DONE: begin
                done             = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Drives directed and random hands into baccarat_fsm and checks every cycle
// against a card-rule model of the expected dealing sequence.
module tb_baccarat_fsm;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, done;

    int vectors;
    int miscompares;

    baccarat_fsm dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Strobe bit positions within the 6-bit pattern {p1,p2,p3,d1,d2,d3}
    localparam logic [5:0] S_P1 = 6'b100000;
    localparam logic [5:0] S_P2 = 6'b010000;
    localparam logic [5:0] S_P3 = 6'b001000;
    localparam logic [5:0] S_D1 = 6'b000100;
    localparam logic [5:0] S_D2 = 6'b000010;
    localparam logic [5:0] S_D3 = 6'b000001;

    function automatic logic [8:0] observed();
        return {load_pcard1, load_pcard2, load_pcard3,
                load_dcard1, load_dcard2, load_dcard3,
                player_win_light, dealer_win_light, done};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = observed();
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b (p1p2p3d1d2d3 pw dw done)", tag, obs, exp);
        end
    endtask

    // Punto banco rules, from the card values rather than any state machine.
    function automatic logic banker_rule(input int d, input int card);
        int v;
        v = (card <= 9) ? card : 0;
        if (d <= 2) return 1'b1;
        if (d == 3) return (v != 8);
        if (d == 4) return (v >= 2 && v <= 7);
        if (d == 5) return (v >= 4 && v <= 7);
        if (d == 6) return (v >= 6 && v <= 7);
        return 1'b0;
    endfunction

    task automatic run_hand(input string tag, input int p0, input int d0, input int c3,
                            input int pf, input int df);
        logic [5:0] seq[$];
        bit nat, pdraw, bdraw;
        int final_from;
        logic [8:0] exp;
        nat   = (p0 >= 8) || (d0 >= 8);
        pdraw = !nat && (p0 <= 5);
        if (nat)        bdraw = 0;
        else if (pdraw) bdraw = banker_rule(d0, c3);
        else            bdraw = (d0 <= 5);
        seq = '{S_P1, S_D1, S_P2, S_D2, 6'b0};
        if (pdraw) begin
            seq.push_back(S_P3);
            seq.push_back(6'b0);
        end
        if (bdraw) seq.push_back(S_D3);
        final_from = pdraw ? 8 : 6;

        resetb = 1'b0;
        pscore = 4'(p0);
        dscore = 4'(d0);
        pcard3 = 4'($urandom_range(0, 13));
        @(posedge slow_clock); #1;
        check({tag, "/rst"}, 9'b0);
        resetb = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge slow_clock); #1;
            if (cyc >= final_from) begin
                pscore = 4'(pf);
                dscore = 4'(df);
            end
            pcard3 = (cyc >= 6) ? 4'(c3) : 4'($urandom_range(0, 13));
            #1;
            if (cyc <= seq.size())
                exp = {seq[cyc-1], 3'b000};
            else
                exp = {6'b0, (pscore >= dscore), (dscore >= pscore), 1'b1};
            check($sformatf("%s/c%0d", tag, cyc), exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetb      = 1'b0;
        pscore      = 4'd0;
        dscore      = 4'd0;
        pcard3      = 4'd0;
        repeat (2) @(posedge slow_clock);

        run_hand("natural",    8, 3, 5,  8, 3);
        run_hand("both_draw",  4, 5, 4,  6, 7);
        run_hand("p_stands",   6, 5, 0,  6, 6);
        run_hand("face_card",  2, 6, 12, 2, 6);
        run_hand("b3_v3_8",    1, 3, 8,  9, 3);
        run_hand("b3_v3_9",    1, 3, 9,  0, 5);
        run_hand("both_stand", 7, 6, 3,  7, 6);
        run_hand("dnat9",      0, 9, 1,  0, 9);
        run_hand("b7_stands",  3, 7, 6,  9, 7);

        // Reset asserted while the player's third card is being loaded.
        resetb = 1'b0;
        pscore = 4'd4;
        dscore = 4'd5;
        pcard3 = 4'd4;
        @(posedge slow_clock); #1;
        resetb = 1'b1;
        repeat (6) @(posedge slow_clock);
        #1;
        check("midreset/p3", {S_P3, 3'b000});
        resetb = 1'b0;
        @(posedge slow_clock); #1;
        check("midreset/rst", 9'b0);
        resetb = 1'b1;
        @(posedge slow_clock); #1;
        check("midreset/p1", {S_P1, 3'b000});

        for (int h = 0; h < 40; h++) begin
            run_hand($sformatf("rand%0d", h),
                     int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                     int'($urandom_range(0, 13)),
                     int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
